pio_rx_reader: RTL and testbench



---
 rtl/pio_pkg.sv | 19 +
 rtl/pio_rx_fifo.sv | 59 +++++
 rtl/pio_rx_reader.sv | 125 ++++++++++++
 tb/tb_pio_rx_reader.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pio_pkg.sv
// rtl/pio_pkg.sv - shared PIO host-bus action codes, sizes and reader states
package pio_pkg;

  localparam logic [3:0] ACT_NOP   = 4'd0;
  localparam logic [3:0] ACT_INSTR = 4'd1;
  localparam logic [3:0] ACT_PUSH  = 4'd4;
  localparam logic [3:0] ACT_PULL  = 4'd5;

  localparam int NSM    = 4;
  localparam int SM_W   = $clog2(NSM);
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PULL = 2'd1,
    ST_WAIT = 2'd2
  } rx_state_t;

endpackage

// File: rtl/pio_rx_fifo.sv
// rtl/pio_rx_fifo.sv - first-word-fall-through FIFO holding {machine, word} entries
module pio_rx_fifo
  import pio_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = DATA_W + SM_W
) (
  input  logic                     clk,
  input  logic                     n_reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full      = (count == CNT_W'(DEPTH));
  assign do_pop    = pop && (count != '0);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_push   = push && (!full || do_pop);
  assign overflow  = push && !do_push;
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pio_rx_reader.sv
// rtl/pio_rx_reader.sv - round-robin PULL of PIO RX FIFOs into a buffered valid/ready stream
module pio_rx_reader #(
  parameter logic [3:0] ACT_PULL = pio_pkg::ACT_PULL,
  parameter int         PULL_LAT = 1,
  parameter int         DEPTH    = 4,
  parameter int         NSM      = pio_pkg::NSM
) (
  input  logic                     clk,
  input  logic                     n_reset,
  input  logic [NSM-1:0]           sm_enable,
  input  logic [NSM-1:0]           rx_empty,
  input  logic [31:0]              dout,
  output logic [3:0]               action,
  output logic [$clog2(NSM)-1:0]   mindex,
  output logic [31:0]              m_data,
  output logic [$clog2(NSM)-1:0]   m_sm,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     busy,
  output logic                     overflow_err
);

  localparam int SM_W  = $clog2(NSM);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  pio_pkg::rx_state_t state_q, state_d;

  logic [SM_W-1:0]  rr_q, rr_d;
  logic [SM_W-1:0]  sel;
  logic             found;
  logic [NSM-1:0]   cand;
  logic [SM_W-1:0]  mindex_d;
  logic [3:0]       action_d;
  logic [1:0]       wait_q, wait_d;
  logic             busy_d;
  logic             fifo_push;
  logic             fifo_ovf;
  logic [CNT_W-1:0] fifo_count;

  assign cand = sm_enable & ~rx_empty;

  // Walk offsets from high to low so the candidate nearest rr wins.
  always_comb begin
    found = 1'b0;
    sel   = rr_q;
    for (int i = NSM - 1; i >= 0; i--) begin
      int idx;
      idx = (int'(rr_q) + i) % NSM;
      if (cand[idx]) begin
        found = 1'b1;
        sel   = SM_W'(idx);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    action_d  = pio_pkg::ACT_NOP;
    mindex_d  = mindex;
    rr_d      = rr_q;
    wait_d    = wait_q;
    fifo_push = 1'b0;
    unique case (state_q)
      pio_pkg::ST_IDLE: begin
        if (found && (fifo_count < CNT_W'(DEPTH))) begin
          action_d = ACT_PULL;
          mindex_d = sel;
          rr_d     = (sel == SM_W'(NSM - 1)) ? '0 : sel + 1'b1;
          state_d  = pio_pkg::ST_PULL;
        end
      end
      pio_pkg::ST_PULL: begin
        wait_d  = 2'(PULL_LAT - 1);
        state_d = pio_pkg::ST_WAIT;
      end
      pio_pkg::ST_WAIT: begin
        if (wait_q == '0) begin
          fifo_push = 1'b1;
          state_d   = pio_pkg::ST_IDLE;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      default: state_d = pio_pkg::ST_IDLE;
    endcase
    busy_d = (state_d != pio_pkg::ST_IDLE);
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q      <= pio_pkg::ST_IDLE;
      rr_q         <= '0;
      wait_q       <= '0;
      action       <= pio_pkg::ACT_NOP;
      mindex       <= '0;
      busy         <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      wait_q       <= wait_d;
      action       <= action_d;
      mindex       <= mindex_d;
      busy         <= busy_d;
      overflow_err <= overflow_err | fifo_ovf;
    end
  end

  pio_rx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (SM_W + 32)
  ) u_fifo (
    .clk       (clk),
    .n_reset   (n_reset),
    .push      (fifo_push),
    .push_data ({mindex, dout}),
    .pop       (m_valid && m_ready),
    .head_data ({m_sm, m_data}),
    .count     (fifo_count),
    .overflow  (fifo_ovf)
  );

  assign m_valid = (fifo_count != '0);

endmodule

// File: tb/tb_pio_rx_reader.sv
// tb/tb_pio_rx_reader.sv - directed self-checking bench for pio_rx_reader
module tb_pio_rx_reader;
  import pio_pkg::*;

  localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic [3:0]  sm_enable = 4'b0000;
  logic [3:0]  rx_empty;
  logic [31:0] dout;
  logic [3:0]  action;
  logic [1:0]  mindex;
  logic [31:0] m_data;
  logic [1:0]  m_sm;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        busy;
  logic        overflow_err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [31:0] src_mem [4][64];
  logic [5:0]  src_wr [4];
  logic [5:0]  src_rd [4];
  logic [1:0]  stage;
  logic [31:0] pend;
  logic [1:0]  pull_m [$];
  int          pull_cyc [$];
  logic [33:0] out_log [$];

  pio_rx_reader dut (
    .clk          (clk),
    .n_reset      (n_reset),
    .sm_enable    (sm_enable),
    .rx_empty     (rx_empty),
    .dout         (dout),
    .action       (action),
    .mindex       (mindex),
    .m_data       (m_data),
    .m_sm         (m_sm),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .busy         (busy),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    rx_empty = 4'b0000;
    for (int m = 0; m < 4; m++) begin
      rx_empty[m] = (src_wr[m] == src_rd[m]);
    end
  end

  // PIO model: pop on the action cycle, word valid only in the following cycle.
  always @(negedge clk) begin
    if (!n_reset) begin
      stage <= 2'd0;
      dout  <= JUNK;
      for (int m = 0; m < 4; m++) src_rd[m] <= '0;
    end else if (action == ACT_PULL) begin
      pull_m.push_back(mindex);
      pull_cyc.push_back(cyc);
      pend           <= src_mem[mindex][src_rd[mindex]];
      src_rd[mindex] <= src_rd[mindex] + 6'd1;
      dout           <= JUNK;
      stage          <= 2'd1;
    end else if (stage == 2'd1) begin
      dout  <= pend;
      stage <= 2'd2;
    end else if (stage == 2'd2) begin
      dout  <= JUNK;
      stage <= 2'd0;
    end
  end

  always @(negedge clk) begin
    if (n_reset && m_valid && m_ready) out_log.push_back({m_sm, m_data});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input int m, input logic [31:0] w);
    src_mem[m][src_wr[m]] = w;
    src_wr[m] = src_wr[m] + 6'd1;
  endtask

  task automatic do_reset();
    n_reset   = 1'b0;
    m_ready   = 1'b0;
    sm_enable = 4'b0000;
    for (int m = 0; m < 4; m++) src_wr[m] = '0;
    tick(2);
    n_reset = 1'b1;
  endtask

  task automatic wait_pulls(input string tag, input int target, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      if (pull_m.size() >= target) break;
      tick(1);
    end
    check(tag, 64'(pull_m.size() >= target), 64'd1);
  endtask

  task automatic wait_outs(input string tag, input int target, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      if (out_log.size() >= target) break;
      tick(1);
    end
    check(tag, 64'(out_log.size() >= target), 64'd1);
  endtask

  initial begin
    int pb;
    int ob;
    int seen;
    logic [31:0] w;
    logic [1:0]  mm;

    // 1: reset values, then a single word from machine 0
    for (int m = 0; m < 4; m++) src_wr[m] = '0;
    tick(2);
    check("rst_action", 64'(action), 64'd0);
    check("rst_mindex", 64'(mindex), 64'd0);
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_data", 64'(m_data), 64'd0);
    check("rst_m_sm", 64'(m_sm), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_overflow", 64'(overflow_err), 64'd0);
    sm_enable = 4'b0001;
    load(0, 32'hDEADBEEF);
    pb = pull_m.size();
    ob = out_log.size();
    n_reset = 1'b1;
    tick(12);
    check("t1_pulls", 64'(pull_m.size() - pb), 64'd1);
    check("t1_mindex", 64'(pull_m[pb]), 64'd0);
    check("t1_m_valid", 64'(m_valid), 64'd1);
    check("t1_m_data", 64'(m_data), 64'hDEADBEEF);
    check("t1_m_sm", 64'(m_sm), 64'd0);
    check("t1_busy", 64'(busy), 64'd0);
    m_ready = 1'b1;
    tick(1);
    m_ready = 1'b0;
    check("t1_popped", 64'(out_log[ob]), 64'h0_DEADBEEF);
    check("t1_empty", 64'(m_valid), 64'd0);

    // 2: round-robin fairness and pull spacing
    do_reset();
    sm_enable = 4'b1111;
    for (int r = 0; r < 2; r++)
      for (int m = 0; m < 4; m++) load(m, 32'h1000_0000 + 32'(m));
    m_ready = 1'b1;
    pb = pull_m.size();
    ob = out_log.size();
    wait_pulls("t2_wait_pulls", pb + 8, 60);
    wait_outs("t2_wait_outs", ob + 8, 20);
    for (int i = 0; i < 8; i++) begin
      mm = 2'(i % 4);
      check($sformatf("t2_order%0d", i), 64'(pull_m[pb + i]), 64'(mm));
      check($sformatf("t2_out%0d", i), 64'(out_log[ob + i]), 64'({mm, 32'h1000_0000 + 32'(mm)}));
      if (i > 0) check($sformatf("t2_space%0d", i), 64'(pull_cyc[pb + i] - pull_cyc[pb + i - 1]), 64'd3);
    end

    // 3: backpressure stops pulls at DEPTH, draining resumes them
    do_reset();
    sm_enable = 4'b0100;
    for (int k = 1; k <= 6; k++) load(2, 32'h2000_0000 + 32'(k));
    pb = pull_m.size();
    ob = out_log.size();
    tick(40);
    check("t3_pulls_full", 64'(pull_m.size() - pb), 64'd4);
    check("t3_action_idle", 64'(action), 64'd0);
    check("t3_overflow", 64'(overflow_err), 64'd0);
    check("t3_head", 64'({m_sm, m_data}), 64'({2'd2, 32'h2000_0001}));
    m_ready = 1'b1;
    wait_outs("t3_wait_outs", ob + 6, 60);
    check("t3_pulls_total", 64'(pull_m.size() - pb), 64'd6);
    for (int k = 0; k < 6; k++)
      check($sformatf("t3_out%0d", k), 64'(out_log[ob + k]), 64'({2'd2, 32'h2000_0001 + 32'(k)}));

    // 4: streaming 32 words through a FIFO that starts full
    do_reset();
    sm_enable = 4'b0001;
    for (int k = 0; k < 32; k++) load(0, 32'h3000_0000 + 32'(k));
    ob = out_log.size();
    tick(20);
    check("t4_full_head", 64'(m_data), 64'h3000_0000);
    m_ready = 1'b1;
    wait_outs("t4_wait_outs", ob + 32, 300);
    for (int k = 0; k < 32; k++)
      check($sformatf("t4_out%0d", k), 64'(out_log[ob + k]), 64'({2'd0, 32'h3000_0000 + 32'(k)}));
    check("t4_overflow", 64'(overflow_err), 64'd0);

    // 5: enable mask; machine 3 disabled while its pull is in WAIT
    do_reset();
    sm_enable = 4'b1010;
    for (int m = 0; m < 4; m++)
      for (int k = 0; k < 4; k++) load(m, 32'h5000_0000 + 32'(m * 256 + k));
    m_ready = 1'b1;
    pb = pull_m.size();
    ob = out_log.size();
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      tick(1);
      if (action == ACT_PULL && mindex == 2'd3) begin
        seen = 1;
        break;
      end
    end
    check("t5_saw_pull3", 64'(seen), 64'd1);
    tick(1);
    check("t5_busy_wait", 64'(busy), 64'd1);
    sm_enable = 4'b0010;
    tick(30);
    check("t5_pulls", 64'(pull_m.size() - pb), 64'd5);
    for (int i = 0; i < 5; i++) begin
      mm = (i == 1) ? 2'd3 : 2'd1;
      w  = 32'h5000_0000 + {22'd0, mm, 8'd0} + ((i == 0 || i == 1) ? 32'd0 : 32'(i - 1));
      check($sformatf("t5_order%0d", i), 64'(pull_m[pb + i]), 64'(mm));
      check($sformatf("t5_out%0d", i), 64'(out_log[ob + i]), 64'({mm, w}));
    end

    // 6: asynchronous reset in WAIT, then rr restarts at 0
    do_reset();
    sm_enable = 4'b0100;
    load(2, 32'hA000_0001);
    load(2, 32'hA000_0002);
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      tick(1);
      if (action == ACT_PULL) seen++;
      if (seen == 2) break;
    end
    check("t6_two_pulls", 64'(seen), 64'd2);
    tick(1);
    check("t6_busy_pre", 64'(busy), 64'd1);
    check("t6_valid_pre", 64'(m_valid), 64'd1);
    #2;
    n_reset = 1'b0;
    #1;
    check("t6_action_async", 64'(action), 64'd0);
    check("t6_busy_async", 64'(busy), 64'd0);
    check("t6_valid_async", 64'(m_valid), 64'd0);
    check("t6_data_async", 64'(m_data), 64'd0);
    check("t6_mindex_async", 64'(mindex), 64'd0);
    for (int m = 0; m < 4; m++) src_wr[m] = '0;
    tick(2);
    n_reset = 1'b1;
    sm_enable = 4'b1111;
    load(3, 32'hB000_0003);
    load(0, 32'hB000_0000);
    pb = pull_m.size();
    wait_pulls("t6_wait_pull", pb + 1, 10);
    check("t6_first_after_reset", 64'(pull_m[pb]), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
